// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage controller placed directly in front of the combinational
// load/store unit. It accepts one op from EX, checks its alignment, and
// drives the unit's read/write port. Returned load data is sign- or
// zero-extended, and the result is handed to WB. Only one op is in flight
// at a time, using a three-state FSM (IDLE -> ACCESS -> DONE).
//
// Optional build feature:
//   MEM_ACCESS_PERF_EN - adds 64-bit perf_loads / perf_stores counters.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   in_valid/in_ready     EX handshake; in_ready is high only in IDLE
//   in_addr, in_wdata     effective address; store data or pass-through value
//   in_is_load/is_store   op kind (never both set); neither = pass-through
//   in_size, in_unsigned  access size (B/H/W/D), zero-extend a load
//   in_rd                 destination register index
//   mem_raddr/mem_rdata   LSU read port (rdata arrives right-aligned)
//   mem_wvalid/waddr/
//   mem_wdata/mem_wmask   LSU write port (data lane-shifted, mask unshifted)
//   mem_ready             memory completes the access this cycle
//   out_valid/out_ready   WB handshake
//   out_data, out_rd,
//   out_wen, out_misalign result to WB
//   perf_loads/stores     completed load/store counts (feature build only)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [RD_W-1:0] in_rd,
    output logic [XLEN-1:0] mem_raddr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_wvalid,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic            out_misalign
`ifdef MEM_ACCESS_PERF_EN
  , output logic [63:0]     perf_loads,
    output logic [63:0]     perf_stores
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched request
    logic [XLEN-1:0] addr_q,     addr_d;
    logic [XLEN-1:0] wdata_q,    wdata_d;
    logic            is_load_q,  is_load_d;
    logic            is_store_q, is_store_d;
    logic [1:0]      size_q,     size_d;
    logic            uns_q,      uns_d;

    // Result held for WB
    logic [XLEN-1:0] out_data_q,     out_data_d;
    logic [RD_W-1:0] out_rd_q,       out_rd_d;
    logic            out_wen_q,      out_wen_d;
    logic            out_misalign_q, out_misalign_d;

    // Natural alignment check; byte accesses can never fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = (low[0] != 1'b0);
            2'd2:    mis = (low[1:0] != 2'b00);
            2'd3:    mis = (low != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Extend the low bytes of right-aligned load data; D ignores unsigned.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                     input logic [1:0]      size,
                                                     input logic            uns);
        logic [XLEN-1:0] res;
        case (size)
            2'd0:    res = {{(XLEN-8){raw[7] & ~uns}}, raw[7:0]};
            2'd1:    res = {{(XLEN-16){raw[15] & ~uns}}, raw[15:0]};
            2'd2:    res = {{(XLEN-32){raw[31] & ~uns}}, raw[31:0]};
            2'd3:    res = raw;
            default: res = raw;
        endcase
        return res;
    endfunction

    // Byte-enable mask before lane offset; the LSU applies addr[2:0] itself.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            2'd3:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Next-state and result computation for the three-state op FSM.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        is_load_d      = is_load_q;
        is_store_d     = is_store_q;
        size_d         = size_q;
        uns_d          = uns_q;
        out_data_d     = out_data_q;
        out_rd_d       = out_rd_q;
        out_wen_d      = out_wen_q;
        out_misalign_d = out_misalign_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    is_load_d  = in_is_load;
                    is_store_d = in_is_store;
                    size_d     = in_size;
                    uns_d      = in_unsigned;
                    out_rd_d   = in_rd;
                    // Alignment only matters for ops that actually touch memory.
                    if ((in_is_load || in_is_store) && is_misaligned(in_size, in_addr[2:0])) begin
                        out_misalign_d = 1'b1;
                        out_wen_d      = 1'b0;
                        out_data_d     = {XLEN{1'b0}};
                        state_d        = S_DONE;
                    end else if (in_is_load || in_is_store) begin
                        out_misalign_d = 1'b0;
                        out_wen_d      = in_is_load && (in_rd != {RD_W{1'b0}});
                        out_data_d     = {XLEN{1'b0}};
                        state_d        = S_ACCESS;
                    end else begin
                        out_misalign_d = 1'b0;
                        out_wen_d      = (in_rd != {RD_W{1'b0}});
                        out_data_d     = in_wdata;
                        state_d        = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    if (is_load_q) begin
                        out_data_d = load_extend(mem_rdata, size_q, uns_q);
                    end else begin
                        out_data_d = out_data_q;
                    end
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request and result registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= {XLEN{1'b0}};
            wdata_q        <= {XLEN{1'b0}};
            is_load_q      <= 1'b0;
            is_store_q     <= 1'b0;
            size_q         <= 2'd0;
            uns_q          <= 1'b0;
            out_data_q     <= {XLEN{1'b0}};
            out_rd_q       <= {RD_W{1'b0}};
            out_wen_q      <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            is_load_q      <= is_load_d;
            is_store_q     <= is_store_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            out_data_q     <= out_data_d;
            out_rd_q       <= out_rd_d;
            out_wen_q      <= out_wen_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_data     = out_data_q;
    assign out_rd       = out_rd_q;
    assign out_wen      = out_wen_q;
    assign out_misalign = out_misalign_q;

    // Write enable only while in ACCESS; held across mem_ready stalls.
    assign mem_wvalid = (state_q == S_ACCESS) && is_store_q;
    assign mem_raddr  = addr_q;
    assign mem_waddr  = addr_q;
    assign mem_wdata  = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_wmask  = size_mask(size_q);

`ifdef MEM_ACCESS_PERF_EN
    logic [63:0] perf_loads_q, perf_loads_d;
    logic [63:0] perf_stores_q, perf_stores_d;
    logic        access_done_s;

    // Count completions only; misaligned ops never reach ACCESS.
    always_comb begin
        access_done_s = (state_q == S_ACCESS) && mem_ready;
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        if (access_done_s && is_load_q) begin
            perf_loads_d = perf_loads_q + 64'd1;
        end else begin
            perf_loads_d = perf_loads_q;
        end
        if (access_done_s && is_store_q) begin
            perf_stores_d = perf_stores_q + 64'd1;
        end else begin
            perf_stores_d = perf_stores_q;
        end
    end

    // Performance counter registers, wrapping naturally at 2^64.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_loads_q  <= 64'd0;
            perf_stores_q <= 64'd0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] in_addr, in_wdata;
    logic        in_is_load, in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic [63:0] mem_raddr, mem_rdata;
    logic        mem_wvalid;
    logic [63:0] mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen, out_misalign;
`ifdef MEM_ACCESS_PERF_EN
    logic [63:0] perf_loads, perf_stores;
`endif

    mem_access_ctrl #(.XLEN(64), .RD_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd),
        .out_wen(out_wen), .out_misalign(out_misalign)
`ifdef MEM_ACCESS_PERF_EN
      , .perf_loads(perf_loads), .perf_stores(perf_stores)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_loads  = 0;
    int   exp_stores = 0;

    // Write-port monitor: sampled on the active edge, pre-update values.
    int          wv_cycles = 0;
    int          wacc      = 0;
    logic [63:0] last_wdata = 64'd0;
    logic [7:0]  last_wmask = 8'd0;
    logic [63:0] last_waddr = 64'd0;
    always @(posedge clock) begin
        if (mem_wvalid) wv_cycles <= wv_cycles + 1;
        if (mem_wvalid && mem_ready) begin
            wacc       <= wacc + 1;
            last_wdata <= mem_wdata;
            last_wmask <= mem_wmask;
            last_waddr <= mem_waddr;
        end
    end

    // Present one op at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        in_is_load = ld; in_is_store = st; in_size = sz; in_unsigned = uns;
        in_addr = addr; in_wdata = wd; in_rd = rd; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts cycles since the accept edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({in_ready, out_valid, out_data, out_rd, out_wen, out_misalign, mem_wvalid, mem_raddr} !==
            {1'b1, 1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h rd=%0d wen=%b mis=%b wv=%b raddr=%h, required 1 0 0 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_rd, out_wen, out_misalign, mem_wvalid, mem_raddr);
        end
`ifdef MEM_ACCESS_PERF_EN
        n_checks++;
        if ({perf_loads, perf_stores} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_perf: loads=%0d stores=%0d, required 0 0", perf_loads, perf_stores);
        end
`endif
    endtask

    // Generic single-op scenario: push expectation, send, pop and compare.
    task automatic run_op(input string name, input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [4:0] rd, input int exp_lat, input exp_t e);
        int   lat;
        exp_t x;
        sb.push_back(e);
        send(ld, st, sz, uns, addr, wd, rd);
        wait_valid(lat);
        x = sb.pop_front();
        n_checks++;
        if (lat !== exp_lat || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d (valid=%b), required %0d", name, lat, out_valid, exp_lat);
        end
        n_checks++;
        if ({out_rd, out_wen, out_misalign} !== {x.rd, x.wen, x.mis} ||
            (x.chk_data && out_data !== x.data)) begin
            n_fail++;
            $display("FAIL %s_result: data=%h rd=%0d wen=%b mis=%b, required data=%h rd=%0d wen=%b mis=%b",
                     name, out_data, out_rd, out_wen, out_misalign, x.data, x.rd, x.wen, x.mis);
        end
        @(negedge clock);
    endtask

    task automatic test_load_w;
        mem_rdata = 64'h0000_0000_F000_1234;
        run_op("load_w", 1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 5'd5, 2,
               '{data: 64'hFFFF_FFFF_F000_1234, rd: 5'd5, wen: 1'b1, mis: 1'b0, chk_data: 1'b1});
        n_checks++;
        if (mem_raddr !== 64'h8000_0004) begin
            n_fail++;
            $display("FAIL load_w_raddr: got %h, required 0000000080000004", mem_raddr);
        end
        exp_loads++;
    endtask

    task automatic test_load_b;
        mem_rdata = 64'h1234_5678_9ABC_DE80;
        run_op("load_bu", 1'b1, 1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 5'd9, 2,
               '{data: 64'h0000_0000_0000_0080, rd: 5'd9, wen: 1'b1, mis: 1'b0, chk_data: 1'b1});
        run_op("load_b", 1'b1, 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 5'd9, 2,
               '{data: 64'hFFFF_FFFF_FFFF_FF80, rd: 5'd9, wen: 1'b1, mis: 1'b0, chk_data: 1'b1});
        exp_loads += 2;
    endtask

    task automatic test_store_h;
        int b_wv, b_acc;
        b_wv = wv_cycles; b_acc = wacc;
        run_op("store_h", 1'b0, 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 5'd4, 2,
               '{data: 64'd0, rd: 5'd4, wen: 1'b0, mis: 1'b0, chk_data: 1'b0});
        n_checks++;
        if (wv_cycles - b_wv !== 1 || wacc - b_acc !== 1 || last_wdata !== 64'hABCD_0000_0000_0000 ||
            last_wmask !== 8'h03 || last_waddr !== 64'h8000_0006) begin
            n_fail++;
            $display("FAIL store_h_port: wv=%0d acc=%0d wdata=%h wmask=%h waddr=%h, required 1 1 abcd000000000000 03 80000006",
                     wv_cycles - b_wv, wacc - b_acc, last_wdata, last_wmask, last_waddr);
        end
        exp_stores++;
    endtask

    task automatic test_misalign;
        int b_wv;
        b_wv = wv_cycles;
        run_op("mis_store_d", 1'b0, 1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 1,
               '{data: 64'd0, rd: 5'd6, wen: 1'b0, mis: 1'b1, chk_data: 1'b1});
        run_op("mis_load_w", 1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 5'd7, 1,
               '{data: 64'd0, rd: 5'd7, wen: 1'b0, mis: 1'b1, chk_data: 1'b1});
        run_op("mis_load_h", 1'b1, 1'b0, 2'd1, 1'b1, 64'h8000_0001, 64'd0, 5'd7, 1,
               '{data: 64'd0, rd: 5'd7, wen: 1'b0, mis: 1'b1, chk_data: 1'b1});
        n_checks++;
        if (wv_cycles !== b_wv) begin
            n_fail++;
            $display("FAIL misalign_no_write: wvalid cycles %0d, required 0", wv_cycles - b_wv);
        end
    endtask

    task automatic test_passthru;
        run_op("pass", 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd7, 1,
               '{data: 64'hDEAD_BEEF_CAFE_F00D, rd: 5'd7, wen: 1'b1, mis: 1'b0, chk_data: 1'b1});
        run_op("pass_rd0", 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd0, 1,
               '{data: 64'h0123_4567_89AB_CDEF, rd: 5'd0, wen: 1'b0, mis: 1'b0, chk_data: 1'b1});
    endtask

    task automatic test_stall;
        int          b_wv, b_acc;
        logic [70:0] snap;
        exp_t        x;
        b_wv = wv_cycles; b_acc = wacc;
        mem_ready = 1'b0; out_ready = 1'b0;
        sb.push_back('{data: 64'd0, rd: 5'd3, wen: 1'b0, mis: 1'b0, chk_data: 1'b0});
        send(1'b0, 1'b1, 2'd2, 1'b0, 64'h8000_0010, 64'h0000_0000_1357_9BDF, 5'd3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem_wvalid !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_access_%0d: wvalid=%b in_ready=%b out_valid=%b, required 1 0 0",
                         i, mem_wvalid, in_ready, out_valid);
            end
            @(negedge clock);
        end
        mem_ready = 1'b1;
        @(negedge clock);
        snap = {out_data, out_rd, out_wen, out_misalign};
        x = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {out_rd, out_wen, out_misalign} !== {x.rd, x.wen, x.mis}) begin
            n_fail++;
            $display("FAIL stall_done: valid=%b rd=%0d wen=%b mis=%b, required 1 %0d %b %b",
                     out_valid, out_rd, out_wen, out_misalign, x.rd, x.wen, x.mis);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_data, out_rd, out_wen, out_misalign} !== snap) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b in_ready=%b out=%h, required 1 0 %h",
                         i, out_valid, in_ready, {out_data, out_rd, out_wen, out_misalign}, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || wv_cycles - b_wv !== 4 || wacc - b_acc !== 1 ||
            last_wdata !== 64'h0000_0000_1357_9BDF || last_wmask !== 8'h0F) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b valid=%b wv=%0d acc=%0d wdata=%h wmask=%h, required 1 0 4 1 0000000013579bdf 0f",
                     in_ready, out_valid, wv_cycles - b_wv, wacc - b_acc, last_wdata, last_wmask);
        end
        exp_stores++;
    endtask

    task automatic test_back_to_back;
        logic        ld[3]  = '{1'b1, 1'b0, 1'b1};
        logic        st[3]  = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz[3]  = '{2'd3, 2'd2, 2'd1};
        logic        un[3]  = '{1'b0, 1'b0, 1'b1};
        logic [63:0] ad[3]  = '{64'h8000_0008, 64'h8000_000C, 64'h8000_0002};
        logic [4:0]  rd[3]  = '{5'd1, 5'd2, 5'd0};
        exp_t        ex[3];
        int          acc[3];
        int          idx = 0;
        int          got = 0;
        exp_t        x;
        ex[0] = '{data: 64'h8000_0000_0000_8001, rd: 5'd1, wen: 1'b1, mis: 1'b0, chk_data: 1'b1};
        ex[1] = '{data: 64'd0, rd: 5'd2, wen: 1'b0, mis: 1'b0, chk_data: 1'b0};
        ex[2] = '{data: 64'h0000_0000_0000_8001, rd: 5'd0, wen: 1'b0, mis: 1'b0, chk_data: 1'b1};
        mem_rdata = 64'h8000_0000_0000_8001;
        mem_ready = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            if (out_valid) begin
                x = sb.pop_front();
                n_checks++;
                if ({out_rd, out_wen, out_misalign} !== {x.rd, x.wen, x.mis} ||
                    (x.chk_data && out_data !== x.data)) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: data=%h rd=%0d wen=%b mis=%b, required data=%h rd=%0d wen=%b mis=%b",
                             got, out_data, out_rd, out_wen, out_misalign, x.data, x.rd, x.wen, x.mis);
                end
                got++;
            end
            if (idx < 3) begin
                in_is_load = ld[idx]; in_is_store = st[idx]; in_size = sz[idx]; in_unsigned = un[idx];
                in_addr = ad[idx]; in_wdata = 64'h1122_3344_5566_7788; in_rd = rd[idx]; in_valid = 1'b1;
                if (in_ready) begin
                    sb.push_back(ex[idx]);
                    acc[idx] = cyc;
                    idx++;
                end
            end else begin
                in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 3 || idx !== 3 || acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
            n_fail++;
            $display("FAIL b2b_throughput: results=%0d accepts=%0d gaps=%0d,%0d, required 3 3 3,3",
                     got, idx, acc[1] - acc[0], acc[2] - acc[1]);
        end
        n_checks++;
        if (last_wdata !== 64'h5566_7788_0000_0000 || last_wmask !== 8'h0F) begin
            n_fail++;
            $display("FAIL b2b_store_lane: wdata=%h wmask=%h, required 5566778800000000 0f", last_wdata, last_wmask);
        end
        exp_loads += 2; exp_stores++;
        @(negedge clock);
    endtask

    task automatic test_perf;
`ifdef MEM_ACCESS_PERF_EN
        n_checks++;
        if (perf_loads !== 64'(exp_loads) || perf_stores !== 64'(exp_stores)) begin
            n_fail++;
            $display("FAIL perf_counts: loads=%0d stores=%0d, required %0d %0d",
                     perf_loads, perf_stores, exp_loads, exp_stores);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int b_acc;
        b_acc = wacc;
        mem_ready = 1'b0;
        send(1'b0, 1'b1, 2'd3, 1'b0, 64'h8000_0020, 64'hAAAA_5555_AAAA_5555, 5'd8);
        n_checks++;
        if (mem_wvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pending: wvalid=%b, required 1", mem_wvalid);
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (mem_wvalid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || wacc !== b_acc) begin
            n_fail++;
            $display("FAIL rstmid_abandon: wvalid=%b valid=%b in_ready=%b writes=%0d, required 0 0 1 0",
                     mem_wvalid, out_valid, in_ready, wacc - b_acc);
        end
        exp_loads = 0; exp_stores = 0;
        test_perf();
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (wacc !== b_acc || mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_late_write: writes=%0d wvalid=%b, required 0 0", wacc - b_acc, mem_wvalid);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = 64'd0; in_wdata = 64'd0;
        in_is_load = 1'b0; in_is_store = 1'b0; in_size = 2'd0; in_unsigned = 1'b0; in_rd = 5'd0;
        mem_rdata = 64'd0; mem_ready = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_load_w();
        test_load_b();
        test_store_h();
        test_misalign();
        test_passthru();
        test_stall();
        test_back_to_back();
        test_perf();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage controller sitting directly upstream of the combinational DPI load/store unit.
- Accepts one load/store/pass-through op from EX via valid/ready, checks alignment, and drives the unit's raddr/waddr/wdata/wmask/wvalid port.
- Sign/zero-extends returned load data and hands the result to WB via valid/ready.
- Holds one op in flight; three-state FSM; `mem_ready` lets a future multi-cycle bus stall it (tied 1 today).

Parameters:
XLEN, 64, datapath and address width
RD_W, 5, destination register index width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  EX presents op
in_ready  output  1  controller accepts op
in_addr  input  XLEN  effective address
in_wdata  input  XLEN  store data, or result for non-memory ops
in_is_load  input  1  op is a load
in_is_store  input  1  op is a store (never both set)
in_size  input  2  0=B, 1=H, 2=W, 3=D
in_unsigned  input  1  zero-extend load
in_rd  input  RD_W  destination register
mem_raddr  output  XLEN  read address to LSU
mem_rdata  input  XLEN  read data, already right-aligned by LSU
mem_wvalid  output  1  write enable to LSU
mem_waddr  output  XLEN  write address to LSU
mem_wdata  output  XLEN  store data shifted left by 8*addr[2:0]
mem_wmask  output  8  unshifted size mask (LSU applies the offset): 0x01/0x03/0x0F/0xFF
mem_ready  input  1  memory completes access this cycle
out_valid  output  1  result valid to WB
out_ready  input  1  WB accepts
out_data  output  XLEN  extended load data, or pass-through value
out_rd  output  RD_W  destination register
out_wen  output  1  register write (load or pass-through, and rd!=0)
out_misalign  output  1  access faulted on alignment, no memory access made

Behaviour:
- All state on the rising edge of `clock`.
- Reset: state=IDLE, out_valid=0, out_data=0, out_rd=0, out_wen=0, out_misalign=0, mem_wvalid=0, all request registers=0.
- Reset mid-operation abandons the op; no further write is issued.
- FSM states: IDLE, ACCESS, DONE.
- `in_ready` = (state==IDLE).
- IDLE + in_valid: latch the request.
  - Misaligned → DONE with out_misalign=1, out_wen=0, out_data=0.
  - Else load/store → ACCESS.
  - Else (pass-through) → DONE with out_data=in_wdata.
- Misaligned means: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0. B is never misaligned.
- ACCESS:
  - mem_raddr and mem_waddr = latched address.
  - mem_wvalid = latched is_store.
  - When mem_ready is high: a load captures the extended mem_rdata into out_data; then → DONE.
  - mem_wvalid is held while mem_ready is low.
  - Exactly one cycle with mem_wvalid=1 and mem_ready=1 per store.
- Outside ACCESS, mem_wvalid=0. mem_raddr keeps its last value; reading in IDLE/DONE is harmless.
- Load extension: take the low 8/16/32/64 bits; sign-extend from the top bit unless unsigned. D ignores unsigned.
- DONE: out_valid=1. If out_ready → IDLE; otherwise out_* are held stable.
- No bypass from DONE to a new accept. Back-to-back throughput is one op per 3 cycles with mem_ready=1 and out_ready=1.
- Latency with mem_ready=1: out_valid is asserted 2 cycles after the accept edge for load/store, 1 cycle for pass-through or misaligned.
- out_wen: 0 for store, 0 for misalign, 0 when rd==0, else 1.

Optional Feature:
- Macro: MEM_ACCESS_PERF_EN.
- When defined:
  - Adds outputs `perf_loads` and `perf_stores` (64 bits each), reset to 0.
  - Each increments by 1 on the cycle a load/store completes in ACCESS (mem_ready=1).
  - Misaligned ops are not counted.
  - Counters wrap at 2^64.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load W, addr=0x80000004, unsigned=0, mem_rdata=0x00000000_F0001234, rd=5 → out_valid 2 cycles after accept; out_data=0xFFFFFFFF_F0001234, out_wen=1, out_rd=5.
- Load B unsigned, addr=0x80000003, mem_rdata=0x...80 → out_data=0x80. Repeat signed → 0xFFFFFFFF_FFFFFF80.
- Store H, addr=0x80000006, wdata=0xABCD → single cycle with mem_wvalid=1, mem_wdata=0xABCD_0000_0000_0000, mem_wmask=0x03; out_wen=0.
- Store D, addr=0x80000004 → out_misalign=1 after 1 cycle, mem_wvalid never asserted, out_data=0.
- mem_ready low 3 cycles during store, then out_ready low 2 cycles in DONE → mem_wvalid held 4 cycles, accepted once; out_* stable; in_ready=0 until the out handshake.
- Reset asserted in ACCESS with a store pending → next cycle state IDLE, mem_wvalid=0, out_valid=0; with MEM_ACCESS_PERF_EN, counters read 0.
